btn_event_ctrl: RTL and testbench



---
 rtl/btn_event_pkg.sv | 17 +
 rtl/btn_debounce_ch.sv | 50 +++++
 rtl/btn_event_ctrl.sv | 115 +++++++++++
 tb/tb_btn_event_ctrl.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/btn_event_pkg.sv
// Shared types and defaults for the push-button event front end.
package btn_event_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    localparam int N_BTN_DEF    = 4;
    localparam int DB_WIDTH_DEF = 16;

    // Width of a button index; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchronizer, press debounce counter,
// debounced level register and a one-cycle rising-edge pulse.
module btn_debounce_ch
    import btn_event_pkg::*;
#(
    parameter int DB_WIDTH = DB_WIDTH_DEF
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_rise
);

    logic                r_sync0;
    logic                r_sync1;
    logic                r_level;
    logic                r_level_d;
    logic [DB_WIDTH-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours, as real hardware does.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_sync0   <= 1'b0;
            r_sync1   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync0   <= btn_in;
            r_sync1   <= r_sync0;
            r_level_d <= r_level;
            // Release is taken immediately; only presses must prove stability.
            if (!r_sync1) begin
                r_cnt   <= '0;
                r_level <= 1'b0;
            end else begin
                r_cnt <= r_cnt + DB_WIDTH'(1);
                if (&r_cnt) begin
                    r_level <= 1'b1;
                end
            end
        end
    end

    assign btn_level = r_level;
    assign btn_rise  = r_level & ~r_level_d;

endmodule

// File: rtl/btn_event_ctrl.sv
// Debounces N_BTN buttons and serialises their presses as one-shot events
// over valid/ready, granting pending presses in round-robin order.
module btn_event_ctrl
    import btn_event_pkg::*;
#(
    parameter int N_BTN    = N_BTN_DEF,
    parameter int DB_WIDTH = DB_WIDTH_DEF
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [N_BTN-1:0]              btn_in,
    output logic [N_BTN-1:0]              btn_level,
    output logic                          evt_valid,
    output logic [id_width(N_BTN)-1:0]    evt_id,
    input  logic                          evt_ready,
    output logic                          evt_drop
);

    localparam int ID_W = id_width(N_BTN);

    logic [N_BTN-1:0] w_level;
    logic [N_BTN-1:0] w_rise;
    logic [N_BTN-1:0] w_clear;
    logic [ID_W-1:0]  w_win;
    logic             w_grant;
    state_t           w_state_next;

    state_t           r_state;
    logic [N_BTN-1:0] r_pending;
    logic [ID_W-1:0]  r_rr_ptr;
    logic [ID_W-1:0]  r_evt_id;
    logic             r_drop;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_debounce_ch #(.DB_WIDTH(DB_WIDTH)) u_ch (
            .clk_in    (clk_in),
            .rst_in    (rst_in),
            .btn_in    (btn_in[i]),
            .btn_level (w_level[i]),
            .btn_rise  (w_rise[i])
        );
    end

    // First pending index after the last grant, wrapping modulo N_BTN.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_BTN-1:0] req,
                                                input logic [ID_W-1:0]  ptr);
        logic [ID_W-1:0] win;
        logic            found;
        int              idx;
        win   = '0;
        found = 1'b0;
        for (int k = 1; k <= N_BTN; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_BTN) idx = idx - N_BTN;
            if (!found && req[ID_W'(idx)]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
        return win;
    endfunction

    always_ff @(posedge clk_in) begin
        if (rst_in) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // NOTE: every signal is given a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_win        = rr_pick(r_pending, r_rr_ptr);
        w_clear      = '0;
        case (r_state)
            IDLE: begin
                if (|r_pending) begin
                    w_grant      = 1'b1;
                    w_state_next = OFFER;
                end
            end
            OFFER: begin
                if (evt_ready) begin
                    if (|r_pending) w_grant      = 1'b1;
                    else            w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
        if (w_grant) w_clear[w_win] = 1'b1;
    end

    // A fresh press on the bit being granted this edge is a new event, not a merge.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_pending <= '0;
            r_rr_ptr  <= ID_W'(N_BTN - 1);
            r_evt_id  <= '0;
            r_drop    <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_clear) | w_rise;
            r_drop    <= r_drop | (|(w_rise & r_pending & ~w_clear));
            if (w_grant) begin
                r_evt_id <= w_win;
                r_rr_ptr <= w_win;
            end
        end
    end

    assign btn_level = w_level;
    assign evt_valid = (r_state == OFFER);
    assign evt_id    = r_evt_id;
    assign evt_drop  = r_drop;

endmodule

// File: tb/tb_btn_event_ctrl.sv
// Directed bench for btn_event_ctrl with N_BTN = 4, DB_WIDTH = 4.
module tb_btn_event_ctrl;

    logic       clk = 1'b0;
    logic       rst_in;
    logic [3:0] btn_in;
    logic [3:0] btn_level;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic       evt_ready;
    logic       evt_drop;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    btn_event_ctrl #(.N_BTN(4), .DB_WIDTH(4)) dut (
        .clk_in    (clk),
        .rst_in    (rst_in),
        .btn_in    (btn_in),
        .btn_level (btn_level),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .evt_ready (evt_ready),
        .evt_drop  (evt_drop)
    );

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        step(2);
        rst_in = 1'b0;
    endtask

    initial begin : stim
        int   cnt;
        logic saw_lvl;
        logic saw_v;

        btn_in    = 4'b0000;
        evt_ready = 1'b0;
        #1;
        do_reset();
        check("reset_level", 32'(btn_level), 32'h0);
        check("reset_valid", 32'(evt_valid), 32'h0);
        check("reset_id",    32'(evt_id),    32'h0);
        check("reset_drop",  32'(evt_drop),  32'h0);

        // Single press on channel 0, consumer always ready.
        evt_ready = 1'b1;
        btn_in    = 4'b0001;
        step(17);
        check("s1_level_e17", 32'(btn_level), 32'h0);
        step(1);
        check("s1_level_e18", 32'(btn_level), 32'h1);
        step(1);
        check("s1_valid_e19", 32'(evt_valid), 32'h0);
        step(1);
        check("s1_valid_e20", 32'(evt_valid), 32'h1);
        check("s1_id_e20",    32'(evt_id),    32'h0);
        cnt = 0;
        for (int c = 0; c < 19; c++) begin
            step(1);
            if (evt_valid) cnt++;
        end
        check("s1_single_evt", 32'(cnt), 32'h0);
        btn_in = 4'b0000;
        step(2);
        check("s1_rel_e2", 32'(btn_level), 32'h1);
        step(1);
        check("s1_rel_e3", 32'(btn_level), 32'h0);

        // Bounce on channel 1: 10 high, 1 low, 10 high, then low.
        saw_lvl = 1'b0;
        saw_v   = 1'b0;
        for (int c = 0; c < 46; c++) begin
            btn_in = (c < 10 || (c >= 11 && c < 21)) ? 4'b0010 : 4'b0000;
            step(1);
            saw_lvl |= btn_level[1];
            saw_v   |= evt_valid;
        end
        check("s2_bounce_level", 32'(saw_lvl), 32'h0);
        check("s2_bounce_event", 32'(saw_v),   32'h0);

        // Simultaneous presses 0 and 2 from reset, consumer stalled.
        do_reset();
        evt_ready = 1'b0;
        btn_in    = 4'b0101;
        step(20);
        for (int c = 0; c < 5; c++) begin
            check("s3_hold_valid", 32'(evt_valid), 32'h1);
            check("s3_hold_id",    32'(evt_id),    32'h0);
            if (c < 4) step(1);
        end
        evt_ready = 1'b1;
        step(1);
        check("s3_b2b_valid", 32'(evt_valid), 32'h1);
        check("s3_b2b_id",    32'(evt_id),    32'h2);
        step(1);
        check("s3_done_valid", 32'(evt_valid), 32'h0);
        evt_ready = 1'b0;
        btn_in    = 4'b0000;
        step(4);

        // Fairness: after grant of 2, channels 0 and 3 together -> 3 first.
        btn_in = 4'b1001;
        step(20);
        check("s4_first_valid", 32'(evt_valid), 32'h1);
        check("s4_first_id",    32'(evt_id),    32'h3);
        evt_ready = 1'b1;
        step(1);
        check("s4_second_valid", 32'(evt_valid), 32'h1);
        check("s4_second_id",    32'(evt_id),    32'h0);
        step(1);
        check("s4_done_valid", 32'(evt_valid), 32'h0);
        evt_ready = 1'b0;
        btn_in    = 4'b0000;
        step(4);

        // Drop: id 1 offered and stalled, channel 3 pressed twice.
        btn_in = 4'b0010;
        step(20);
        check("s5_offer_valid", 32'(evt_valid), 32'h1);
        check("s5_offer_id",    32'(evt_id),    32'h1);
        btn_in = 4'b1010;
        step(19);
        check("s5_drop_before", 32'(evt_drop), 32'h0);
        btn_in = 4'b0010;
        step(4);
        check("s5_rel_level", 32'(btn_level), 32'h2);
        btn_in = 4'b1010;
        step(19);
        check("s5_drop_after", 32'(evt_drop), 32'h1);
        check("s5_still_id1",  32'(evt_id),   32'h1);
        btn_in    = 4'b0000;
        evt_ready = 1'b1;
        step(1);
        check("s5_next_valid", 32'(evt_valid), 32'h1);
        check("s5_next_id",    32'(evt_id),    32'h3);
        step(1);
        check("s5_done_valid", 32'(evt_valid), 32'h0);
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            step(1);
            if (evt_valid) cnt++;
        end
        check("s5_no_extra", 32'(cnt),      32'h0);
        check("s5_sticky",   32'(evt_drop), 32'h1);

        // Reset while offering with a press still pending.
        evt_ready = 1'b0;
        btn_in    = 4'b0101;
        step(20);
        check("s6_pre_valid", 32'(evt_valid), 32'h1);
        check("s6_pre_id",    32'(evt_id),    32'h0);
        check("s6_pre_level", 32'(btn_level), 32'h5);
        rst_in = 1'b1;
        btn_in = 4'b0000;
        step(1);
        rst_in = 1'b0;
        check("s6_rst_valid", 32'(evt_valid), 32'h0);
        check("s6_rst_id",    32'(evt_id),    32'h0);
        check("s6_rst_level", 32'(btn_level), 32'h0);
        check("s6_rst_drop",  32'(evt_drop),  32'h0);
        evt_ready = 1'b1;
        cnt = 0;
        for (int c = 0; c < 30; c++) begin
            step(1);
            if (evt_valid) cnt++;
        end
        check("s6_no_stale", 32'(cnt), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
